// File: rtl/seq_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_if
//  Description : Control/data/status bundle for the serial pattern detector.
//                Optional match_comb signal present when SEQDET_MEALY_EN is set.
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_detector_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             en;
   logic [PAT_W-1:0] cfg_pattern;
   logic             cfg_overlap;
   logic             in_valid;
   logic             in_bit;
   logic             clr_count;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic             busy;
`ifdef SEQDET_MEALY_EN
   logic             match_comb;
`endif

   modport master (
      output en, cfg_pattern, cfg_overlap, in_valid, in_bit, clr_count,
`ifdef SEQDET_MEALY_EN
      input  match_comb,
`endif
      input  match, match_count, busy
   );

   modport slave (
      input  en, cfg_pattern, cfg_overlap, in_valid, in_bit, clr_count,
`ifdef SEQDET_MEALY_EN
      output match_comb,
`endif
      output match, match_count, busy
   );
endinterface
`default_nettype wire

// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector
//  Description : Programmable PAT_W-bit serial pattern detector with overlap
//                control, registered match pulse and saturating match counter.
//                Define SEQDET_MEALY_EN to expose the same-cycle match_comb.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detector #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  wire logic      clock,
   input  wire logic      reset,
   seq_detector_if.slave  bus
);
   localparam int FC_W = $clog2(PAT_W);
   localparam logic [FC_W-1:0] c_FILL_LAST = FC_W'(PAT_W - 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t           r_state;
   logic [PAT_W-2:0] r_hist;
   logic [FC_W-1:0]  r_fill_cnt;
   logic [PAT_W-1:0] r_pat;
   logic             r_ovl;
   logic             r_match;
   logic [CNT_W-1:0] r_count;
   logic             r_busy;

   logic [PAT_W-2:0] w_hist_next;
   logic             w_hit;

   // A 2-bit pattern keeps only one history bit, so there is nothing to shift up
   generate
      if (PAT_W == 2) begin : g_shift_min
         assign w_hist_next = bus.in_bit;
      end else begin : g_shift_wide
         assign w_hist_next = {r_hist[PAT_W-3:0], bus.in_bit};
      end
   endgenerate

   assign w_hit = bus.en & bus.in_valid & (r_state == S_RUN) &
                  ({r_hist, bus.in_bit} == r_pat);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_hist     <= '0;
         r_fill_cnt <= '0;
         r_pat      <= '0;
         r_ovl      <= 1'b0;
         r_match    <= 1'b0;
         r_count    <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_match <= w_hit;

         // Clear wins over a coincident hit; the pulse itself is unaffected
         if (bus.clr_count) begin
            r_count <= '0;
         end else if (w_hit && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (bus.en) begin
                  r_pat      <= bus.cfg_pattern;
                  r_ovl      <= bus.cfg_overlap;
                  r_hist     <= '0;
                  r_fill_cnt <= '0;
                  r_state    <= S_FILL;
                  r_busy     <= 1'b1;
               end
            end
            S_FILL, S_RUN: begin
               if (!bus.en) begin
                  r_state    <= S_IDLE;
                  r_hist     <= '0;
                  r_fill_cnt <= '0;
                  r_busy     <= 1'b0;
               end else if (bus.in_valid) begin
                  if (w_hit && !r_ovl) begin
                     r_state    <= S_FILL;
                     r_hist     <= '0;
                     r_fill_cnt <= '0;
                  end else begin
                     r_hist <= w_hist_next;
                     if (r_state == S_FILL) begin
                        if (r_fill_cnt == c_FILL_LAST) begin
                           r_state <= S_RUN;
                        end else begin
                           r_fill_cnt <= r_fill_cnt + 1'b1;
                        end
                     end
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.match       = r_match;
   assign bus.match_count = r_count;
   assign bus.busy        = r_busy;
`ifdef SEQDET_MEALY_EN
   assign bus.match_comb  = w_hit;
`endif

endmodule
`default_nettype wire
